// File: rtl/axi4l2ahbl_if.sv
// axi4l2ahbl_if: bundles the AXI4-Lite slave port and the AHB-Lite master port
// of the axi4l2ahbl bridge. The "slave" modport is the bridge's own view, because
// the bridge is the AXI slave. The "master" modport is the view of the surrounding
// logic, which is the AXI master and also the AHB peripheral.
interface axi4l2ahbl_if;
  logic [31:0] axi_awaddr;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;
  logic [31:0] axi_araddr;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [31:0] ahb_haddr;
  logic [1:0]  ahb_htrans;
  logic        ahb_hwrite;
  logic [2:0]  ahb_hsize;
  logic [31:0] ahb_hwdata;
  logic [31:0] ahb_hrdata;
  logic        ahb_hready;
  logic        ahb_hresp;

  modport slave (
    input  axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
           axi_araddr, axi_arvalid, axi_rready,
    output axi_awready, axi_wready, axi_bresp, axi_bvalid, axi_arready,
           axi_rdata, axi_rresp, axi_rvalid,
    output ahb_haddr, ahb_htrans, ahb_hwrite, ahb_hsize, ahb_hwdata,
    input  ahb_hrdata, ahb_hready, ahb_hresp
  );

  modport master (
    output axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
           axi_araddr, axi_arvalid, axi_rready,
    input  axi_awready, axi_wready, axi_bresp, axi_bvalid, axi_arready,
           axi_rdata, axi_rresp, axi_rvalid,
    input  ahb_haddr, ahb_htrans, ahb_hwrite, ahb_hsize, ahb_hwdata,
    output ahb_hrdata, ahb_hready, ahb_hresp
  );
endinterface

// File: rtl/axi4l2ahbl.sv
// axi4l2ahbl: AXI4-Lite slave to AHB-Lite master bridge, one transaction in flight.
// Each accepted AXI read or write becomes a single NONSEQ AHB transfer. HRDATA and
// HRESP come back as the AXI R or B response. When reads and writes arrive
// together, they alternate round-robin, and a read wins first after reset.
// Optional macro AXI4L2AHBL_STRB_CHECK_EN: when it is defined, a write with an
// unsupported strobe pattern gets SLVERR and no bus transfer. When it is not
// defined, such a write is issued as a full word write.
module axi4l2ahbl (
  input logic         aclk,
  input logic         areset,
  axi4l2ahbl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] RESP_SLVERR   = 2'b10;

  state_t      state, state_d;
  logic        last_wr;
  logic        cur_wr;
  logic [31:0] haddr_q;
  logic [2:0]  hsize_q;
  logic        hwrite_q;
  logic [31:0] hwdata_q;
  logic [31:0] rdata_q;
  logic [1:0]  resp_q;

  logic        wr_cand;
  logic        rd_cand;
  logic        acc_wr;
  logic        acc_rd;
  logic        resp_done;
  logic        strb_bad;
  logic [2:0]  strb_size;
  logic [1:0]  strb_lane;
  logic [1:0]  htrans_d;
  logic        bvalid_d;
  logic        rvalid_d;
  logic        unused_addr_bits;

  // Translate the write strobe into an AHB transfer size and a byte-lane offset.
  // Any strobe pattern not listed here falls back to an aligned word.
  always_comb begin
    strb_size = HSIZE_WORD;
    strb_lane = 2'b00;
    case (bus.axi_wstrb)
      4'b0001: begin strb_size = HSIZE_BYTE; strb_lane = 2'b00; end
      4'b0010: begin strb_size = HSIZE_BYTE; strb_lane = 2'b01; end
      4'b0100: begin strb_size = HSIZE_BYTE; strb_lane = 2'b10; end
      4'b1000: begin strb_size = HSIZE_BYTE; strb_lane = 2'b11; end
      4'b0011: begin strb_size = HSIZE_HALF; strb_lane = 2'b00; end
      4'b1100: begin strb_size = HSIZE_HALF; strb_lane = 2'b10; end
      default: begin strb_size = HSIZE_WORD; strb_lane = 2'b00; end
    endcase
  end

`ifdef AXI4L2AHBL_STRB_CHECK_EN
  assign strb_bad = !(bus.axi_wstrb inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                            4'b0011, 4'b1100, 4'b1111});
`else
  assign strb_bad = 1'b0;
`endif

  // A write needs both AW and W to be valid. The last_wr flag breaks ties.
  assign wr_cand   = bus.axi_awvalid & bus.axi_wvalid;
  assign rd_cand   = bus.axi_arvalid;
  assign acc_wr    = (state == S_IDLE) & ~areset & wr_cand & (~rd_cand | ~last_wr);
  assign acc_rd    = (state == S_IDLE) & ~areset & rd_cand & (~wr_cand | last_wr);
  assign resp_done = (state == S_RESP) & (cur_wr ? bus.axi_bready : bus.axi_rready);

  // Compute the next state and the state-decoded outputs (htrans and the response valids).
  always_comb begin
    state_d  = state;
    htrans_d = HTRANS_IDLE;
    bvalid_d = 1'b0;
    rvalid_d = 1'b0;
    case (state)
      S_IDLE: begin
        if (acc_wr) begin
          state_d = strb_bad ? S_RESP : S_ADDR;
        end else if (acc_rd) begin
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        htrans_d = HTRANS_NONSEQ;
        if (bus.ahb_hready) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bus.ahb_hready) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        bvalid_d = cur_wr;
        rvalid_d = ~cur_wr;
        if (resp_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Datapath. It captures the request at accept time, captures the AHB result at
  // the end of the data phase, and updates the round-robin flag when the AXI side
  // takes the response.
  always_ff @(posedge aclk) begin
    if (areset) begin
      last_wr  <= 1'b1;
      cur_wr   <= 1'b0;
      haddr_q  <= 32'h0;
      hsize_q  <= HSIZE_WORD;
      hwrite_q <= 1'b0;
      hwdata_q <= 32'h0;
      rdata_q  <= 32'h0;
      resp_q   <= RESP_OKAY;
    end else begin
      if (acc_wr) begin
        cur_wr   <= 1'b1;
        hwrite_q <= 1'b1;
        haddr_q  <= {bus.axi_awaddr[31:2], strb_lane};
        hsize_q  <= strb_size;
        hwdata_q <= bus.axi_wdata;
        resp_q   <= strb_bad ? RESP_SLVERR : RESP_OKAY;
      end else if (acc_rd) begin
        cur_wr   <= 1'b0;
        hwrite_q <= 1'b0;
        haddr_q  <= {bus.axi_araddr[31:2], 2'b00};
        hsize_q  <= HSIZE_WORD;
      end
      if ((state == S_DATA) && bus.ahb_hready) begin
        resp_q <= bus.ahb_hresp ? RESP_SLVERR : RESP_OKAY;
        if (!cur_wr) begin
          rdata_q <= bus.ahb_hrdata;
        end
      end
      if (resp_done) begin
        last_wr <= cur_wr;
      end
    end
  end

  // The low address bits come from the strobe (writes) or are forced to zero (reads).
  assign unused_addr_bits = ^{bus.axi_awaddr[1:0], bus.axi_araddr[1:0]};

  assign bus.axi_awready = acc_wr;
  assign bus.axi_wready  = acc_wr;
  assign bus.axi_arready = acc_rd;
  assign bus.axi_bvalid  = bvalid_d;
  assign bus.axi_rvalid  = rvalid_d;
  assign bus.axi_bresp   = resp_q;
  assign bus.axi_rresp   = resp_q;
  assign bus.axi_rdata   = rdata_q;
  assign bus.ahb_htrans  = htrans_d;
  assign bus.ahb_haddr   = haddr_q;
  assign bus.ahb_hsize   = hsize_q;
  assign bus.ahb_hwrite  = hwrite_q;
  assign bus.ahb_hwdata  = hwdata_q;

endmodule

// File: doc/axi4l2ahbl.md
# axi4l2ahbl

AXI4-Lite slave to AHB-Lite master bridge: accepts single AXI4-Lite read and write transactions and replays each one as a single NONSEQ AHB-Lite transfer, returning HRDATA and HRESP as the AXI R/B response. It lets an AXI4-Lite interconnect master reach legacy AHB-Lite peripherals, the reverse direction of the AHB-Lite to AXI4-Lite bridge. One transaction is outstanding at a time; throughput is traded for a small, fully registered AHB side.

## Interface
- No parameters; address and data are fixed at 32 bits.
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  synchronous, active-high reset
- axi_awaddr / axi_awvalid / axi_awready  in / in / out  32/1/1  write address channel
- axi_wdata / axi_wstrb / axi_wvalid / axi_wready  in / in / in / out  32/4/1/1  write data channel
- axi_bresp / axi_bvalid / axi_bready  out / out / in  2/1/1  write response
- axi_araddr / axi_arvalid / axi_arready  in / in / out  32/1/1  read address channel
- axi_rdata / axi_rresp / axi_rvalid / axi_rready  out / out / out / in  32/2/1/1  read data and response
- ahb_haddr  out  32  AHB address
- ahb_htrans  out  2  IDLE=00 or NONSEQ=10 only
- ahb_hwrite  out  1  1 = write
- ahb_hsize  out  3  000 byte, 001 half, 010 word
- ahb_hwdata  out  32  write data, valid in data phase
- ahb_hrdata  in  32  read data
- ahb_hready  in  1  transfer done / bus ready
- ahb_hresp  in  1  1 = ERROR

## Operation
- States: S_IDLE, S_ADDR, S_DATA, S_RESP.
- S_IDLE: write candidate = axi_awvalid & axi_wvalid; read candidate = axi_arvalid. Both present -> round-robin via last_wr flag (reset 1, so read wins first). Winner's ready(s) asserted combinationally in the same cycle; write asserts axi_awready and axi_wready together. Capture address, data, strobe, direction; go S_ADDR.
- AW without W (or W without AW) never accepted alone.
- S_ADDR: drive htrans=NONSEQ, haddr, hwrite, hsize. Advance to S_DATA when ahb_hready=1, else hold all address-phase outputs.
- S_DATA: htrans=IDLE; ahb_hwdata = captured wdata for writes. Wait for ahb_hready=1; then capture ahb_hrdata (reads) and resp = ahb_hresp ? 2'b10 (SLVERR) : 2'b00; go S_RESP. First cycle of a two-cycle ERROR (hready=0) is ignored.
- S_RESP: assert axi_bvalid or axi_rvalid; hold bresp/rresp/rdata stable until bready/rready; then S_IDLE, toggle last_wr accordingly.
- Write strobe mapping: 0001/0010/0100/1000 -> byte, haddr[1:0] = lane index; 0011 -> half, [1:0]=00; 1100 -> half, [1:0]=10; 1111 -> word, [1:0]=00. Any other strobe is illegal (see Configuration).
- Reads: always word, hsize=010, haddr[1:0] forced 00.
- ahb_hwrite/hsize/haddr registered; no combinational path from AXI inputs to AHB outputs.

## Timing
- Reset values: all AXI valid/ready outputs 0, bresp=rresp=00, rdata=0, htrans=00, hwrite=0, hsize=010, haddr=0, hwdata=0, state S_IDLE, last_wr=1.
- Reset mid-transfer: outputs return to reset values next edge; no response issued for the aborted transaction.
- Minimum latency, zero-wait AHB slave: accept at cycle 0, NONSEQ cycle 1, data phase cycle 2, bvalid/rvalid cycle 3; next accept earliest cycle 4 (handshake at cycle 3 with ready=1 returns to S_IDLE at 4).
- Each AHB wait state adds one cycle; hready low during S_ADDR (prior bus owner) stalls the address phase.
- No accept while busy: all AXI readies low outside S_IDLE.

## Configuration
- AXI4L2AHBL_STRB_CHECK_EN defined: illegal strobe (including 0000) issues no AHB transfer; goes S_IDLE -> S_RESP directly with bresp=10 one cycle after accept.
- Undefined: illegal strobe issues word write (hsize=010, [1:0]=00) with all lanes written; bresp from HRESP.

## Test plan
- Write awaddr=0x100, wdata=0xA5A5_1234, wstrb=1111, zero-wait AHB -> NONSEQ haddr=0x100 hsize=010 hwrite=1, hwdata=0xA5A5_1234 next cycle, bvalid=1 bresp=00 at cycle 3.
- Read araddr=0x203, slave inserts 2 wait states, hrdata=0xDEAD_BEEF -> haddr=0x200 hsize=010, rvalid at cycle 5 with rdata=0xDEAD_BEEF rresp=00.
- Write wstrb=0100 addr 0x40 -> haddr=0x42 hsize=000; wstrb=1100 -> haddr=0x42 hsize=001.
- Read with two-cycle AHB ERROR -> rresp=10; rready held low 3 cycles -> rvalid, rdata, rresp stable throughout.
- AW+W and AR valid together from reset, held -> read served first, then write, then read (alternation).
- wstrb=0101: with AXI4L2AHBL_STRB_CHECK_EN, htrans stays 00 and bresp=10; without, word write with bresp=00.
